// File: rtl/q_sys_gpio_pio_if.sv
// Avalon-MM slave bus of the GPIO PIO: 3-bit word address, 32-bit data.
// Latency: writes are zero-wait-state and readdata is combinational.
// Backpressure: none; the slave never stalls the master.
interface q_sys_gpio_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/q_sys_gpio_pio.sv
// GPIO PIO: set/clr/toggle outputs, synchronised inputs with edge capture and a masked level irq; blink via PIO_BLINK_EN.
// Latency: writes land on the next clk edge; in_port to edge_cap is SYNC_STAGES+1 cycles, irq follows one cycle later.
// Backpressure: none; every bus access completes in the cycle it is presented.
module q_sys_gpio_pio #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    BLINK_DIV   = 25000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    q_sys_gpio_pio_if.slave       bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_INPUT   = 3'd1;
    localparam logic [2:0] A_IRQMASK = 3'd2;
    localparam logic [2:0] A_EDGECAP = 3'd3;
    localparam logic [2:0] A_OUTSET  = 3'd4;
    localparam logic [2:0] A_OUTCLR  = 3'd5;
    localparam logic [2:0] A_BLINK   = 3'd6;
    localparam logic [2:0] A_OUTTGL  = 3'd7;

    logic                  wr;
    logic [DATA_WIDTH-1:0] w_dat;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] data_out_next;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] edge_cap;
    logic [DATA_WIDTH-1:0] edge_cap_next;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] in_s;
    logic [DATA_WIDTH-1:0] in_p;
    logic [DATA_WIDTH-1:0] blink_rd;
    logic [DATA_WIDTH-1:0] rd_dat;

    assign wr    = bus.chipselect & ~bus.write_n;
    assign w_dat = bus.writedata[DATA_WIDTH-1:0];
    assign in_s  = sync_q[SYNC_STAGES-1];

    always_comb begin
        data_out_next = data_out;
        if (wr) begin
            case (bus.address)
                A_DATA:   data_out_next = w_dat;
                A_OUTSET: data_out_next = data_out | w_dat;
                A_OUTCLR: data_out_next = data_out & ~w_dat;
                A_OUTTGL: data_out_next = data_out ^ w_dat;
                default:  data_out_next = data_out;
            endcase
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            1:       edge_det = ~in_s & in_p;
            2:       edge_det = in_s ^ in_p;
            default: edge_det = in_s & ~in_p;
        endcase
    end

    // The new edge is OR-ed in after the clear so a simultaneous edge always survives.
    always_comb begin
        edge_cap_next = edge_cap;
        if (wr && bus.address == A_EDGECAP) begin
            edge_cap_next = edge_cap & ~w_dat;
        end
        edge_cap_next = edge_cap_next | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            in_p <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            in_p <= in_s;
        end
    end

    // irq looks at the registered edge_cap, so it trails the capture by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= OUT_RESET;
            irq_mask <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            data_out <= data_out_next;
            edge_cap <= edge_cap_next;
            irq      <= |(edge_cap & irq_mask);
            if (wr && bus.address == A_IRQMASK) begin
                irq_mask <= w_dat;
            end
        end
    end

`ifdef PIO_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0]      blink_cnt;
    logic                  blink_phase;
    logic [DATA_WIDTH-1:0] blink_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            blink_mask  <= '0;
        end else begin
            if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            if (wr && bus.address == A_BLINK) begin
                blink_mask <= w_dat;
            end
        end
    end

    assign blink_rd = blink_mask;
    assign out_port = data_out ^ (blink_mask & {DATA_WIDTH{blink_phase}});
`else
    logic unused_ok;

    assign unused_ok = &{1'b0, 1'((BLINK_DIV % 2) != 0)};
    assign blink_rd  = '0;
    assign out_port  = data_out;
`endif

    always_comb begin
        case (bus.address)
            A_DATA:    rd_dat = data_out;
            A_INPUT:   rd_dat = in_s;
            A_IRQMASK: rd_dat = irq_mask;
            A_EDGECAP: rd_dat = edge_cap;
            A_BLINK:   rd_dat = blink_rd;
            default:   rd_dat = '0;
        endcase
    end

    assign bus.readdata = 32'(rd_dat);

endmodule

// File: tb/tb_q_sys_gpio_pio.sv
// Directed bench for q_sys_gpio_pio: rising-edge instance plus an any-edge instance.
module tb_q_sys_gpio_pio;
    logic       clk;
    logic       reset_n;
    logic [7:0] in_port;
    logic [7:0] out_port;
    logic       irq;
    logic [7:0] in_port_b;
    logic [7:0] out_port_b;
    logic       irq_b;

    int n_pass;
    int n_total;

    q_sys_gpio_pio_if bus ();
    q_sys_gpio_pio_if bus_b ();

    q_sys_gpio_pio #(
        .DATA_WIDTH (8),
        .OUT_RESET  (8'h00),
        .SYNC_STAGES(2),
        .EDGE_TYPE  (0),
        .BLINK_DIV  (4)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .in_port (in_port),
        .out_port(out_port),
        .irq     (irq)
    );

    q_sys_gpio_pio #(
        .DATA_WIDTH (8),
        .OUT_RESET  (8'h00),
        .SYNC_STAGES(2),
        .EDGE_TYPE  (2),
        .BLINK_DIV  (4)
    ) u_dut_any (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave),
        .in_port (in_port_b),
        .out_port(out_port_b),
        .irq     (irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_b_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_b.address    = a;
        bus_b.writedata  = d;
        bus_b.chipselect = 1'b1;
        bus_b.write_n    = 1'b0;
        @(negedge clk);
        bus_b.chipselect = 1'b0;
        bus_b.write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic bus_b_rd(input logic [2:0] a, output logic [31:0] d);
        bus_b.address = a;
        #1;
        d = bus_b.readdata;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset_n = 1'b0;
        in_port = '0;
        in_port_b = '0;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (out_port !== 8'h00) $display("FAIL reset_out_port got=%h exp=00", out_port);
        else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq);
        else n_pass++;
        bus_rd(3'd3, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL reset_edgecap got=%h exp=00000000", rd);
        else n_pass++;
    endtask

    task automatic test_outputs;
        logic [31:0] rd;
        bus_wr(3'd0, 32'h0000_00A5);
        n_total++;
        if (out_port !== 8'hA5) $display("FAIL data_write got=%h exp=a5", out_port);
        else n_pass++;
        bus_rd(3'd0, rd);
        n_total++;
        if (rd !== 32'h0000_00A5) $display("FAIL data_read got=%h exp=000000a5", rd);
        else n_pass++;
        bus_wr(3'd4, 32'h0000_000F);
        n_total++;
        if (out_port !== 8'hAF) $display("FAIL outset got=%h exp=af", out_port);
        else n_pass++;
        bus_wr(3'd5, 32'h0000_0081);
        n_total++;
        if (out_port !== 8'h2E) $display("FAIL outclr got=%h exp=2e", out_port);
        else n_pass++;
        bus_wr(3'd7, 32'h0000_00FF);
        n_total++;
        if (out_port !== 8'hD1) $display("FAIL outtgl got=%h exp=d1", out_port);
        else n_pass++;
    endtask

    task automatic test_bus_qualify;
        logic [31:0] rd;
        @(negedge clk);
        bus.address = 3'd0; bus.writedata = 32'h5A; bus.chipselect = 1'b0; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0;
        n_total++;
        if (out_port !== 8'hD1) $display("FAIL unselected_write got=%h exp=d1", out_port);
        else n_pass++;
        bus_rd(3'd4, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL outset_reads_zero got=%h exp=00000000", rd);
        else n_pass++;
        bus_wr(3'd0, 32'hFFFF_FF3C);
        n_total++;
        if (out_port !== 8'h3C) $display("FAIL wide_write got=%h exp=3c", out_port);
        else n_pass++;
        bus_rd(3'd0, rd);
        n_total++;
        if (rd !== 32'h0000_003C) $display("FAIL zero_extend got=%h exp=0000003c", rd);
        else n_pass++;
    endtask

    task automatic test_edge_irq;
        logic [31:0] rd;
        bus_wr(3'd2, 32'h04);
        @(negedge clk);
        in_port[2] = 1'b1;
        repeat (2) @(negedge clk);
        bus_rd(3'd3, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL edge_latency_early got=%h exp=00000000", rd);
        else n_pass++;
        @(negedge clk);
        bus_rd(3'd3, rd);
        n_total++;
        if (rd !== 32'h04) $display("FAIL edge_capture got=%h exp=00000004", rd);
        else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_lags_capture got=%b exp=0", irq);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (irq !== 1'b1) $display("FAIL irq_assert got=%b exp=1", irq);
        else n_pass++;
        bus_rd(3'd1, rd);
        n_total++;
        if (rd !== 32'h04) $display("FAIL input_read got=%h exp=00000004", rd);
        else n_pass++;
        bus_wr(3'd3, 32'h04);
        bus_rd(3'd3, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL edge_clear got=%h exp=00000000", rd);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_deassert got=%b exp=0", irq);
        else n_pass++;
        in_port[3] = 1'b1;
        repeat (5) @(negedge clk);
        bus_rd(3'd3, rd);
        n_total++;
        if (rd !== 32'h08) $display("FAIL unmasked_capture got=%h exp=00000008", rd);
        else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL unmasked_no_irq got=%b exp=0", irq);
        else n_pass++;
    endtask

    task automatic test_set_wins;
        logic [31:0] rd;
        in_port[2] = 1'b0;
        repeat (4) @(negedge clk);
        in_port[2] = 1'b1;
        repeat (4) @(negedge clk);
        bus_rd(3'd3, rd);
        n_total++;
        if (rd !== 32'h0C) $display("FAIL recapture got=%h exp=0000000c", rd);
        else n_pass++;
        in_port[2] = 1'b0;
        repeat (4) @(negedge clk);
        in_port[2] = 1'b1;
        repeat (2) @(negedge clk);
        bus.address = 3'd3; bus.writedata = 32'h0C; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        bus_rd(3'd3, rd);
        n_total++;
        if (rd !== 32'h04) $display("FAIL set_wins_rising got=%h exp=00000004", rd);
        else n_pass++;
    endtask

    task automatic test_any_edge;
        logic [31:0] rd;
        @(negedge clk);
        in_port_b[2] = 1'b1;
        repeat (4) @(negedge clk);
        bus_b_wr(3'd3, 32'hFF);
        bus_b_rd(3'd3, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL any_clear got=%h exp=00000000", rd);
        else n_pass++;
        in_port_b[2] = 1'b0;
        repeat (2) @(negedge clk);
        bus_b.address = 3'd3; bus_b.writedata = 32'h04; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        @(negedge clk);
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
        bus_b_rd(3'd3, rd);
        n_total++;
        if (rd !== 32'h04) $display("FAIL set_wins_falling got=%h exp=00000004", rd);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        logic [31:0] rd;
        bus_wr(3'd3, 32'hFF);
        bus_wr(3'd2, 32'h03);
        bus_wr(3'd0, 32'hFF);
        in_port[1:0] = 2'b11;
        repeat (5) @(negedge clk);
        bus_rd(3'd3, rd);
        n_total++;
        if (rd !== 32'h03 || irq !== 1'b1 || out_port !== 8'hFF)
            $display("FAIL pre_reset_state edgecap=%h irq=%b out=%h exp=03/1/ff", rd, irq, out_port);
        else n_pass++;
        @(negedge clk);
        bus.address = 3'd0; bus.writedata = 32'h55; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (out_port !== 8'h00 || irq !== 1'b0)
            $display("FAIL async_reset_outputs out=%h irq=%b exp=00/0", out_port, irq);
        else n_pass++;
        bus.address = 3'd3;
        #0.5;
        n_total++;
        if (bus.readdata !== 32'h0) $display("FAIL async_reset_edgecap got=%h exp=00000000", bus.readdata);
        else n_pass++;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        in_port = '0;
        in_port_b = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (out_port !== 8'h00) $display("FAIL post_reset_out got=%h exp=00", out_port);
        else n_pass++;
    endtask

    task automatic test_blink;
        logic [31:0] rd;
        logic [7:0]  v [16];
        bus_wr(3'd0, 32'h01);
        bus_wr(3'd6, 32'h03);
        for (int i = 0; i < 16; i++) begin
            v[i] = out_port;
            @(negedge clk);
        end
        bus_rd(3'd0, rd);
        n_total++;
        if (rd !== 32'h01) $display("FAIL blink_data_read got=%h exp=00000001", rd);
        else n_pass++;
        bus_rd(3'd6, rd);
`ifdef PIO_BLINK_EN
        n_total++;
        if (rd !== 32'h03) $display("FAIL blink_read got=%h exp=00000003", rd);
        else n_pass++;
        begin
            int c;
            c = -1;
            for (int i = 1; i < 16; i++) begin
                if (c < 0 && v[i] !== v[i-1]) c = i;
            end
            n_total++;
            if (c < 1 || c > 4) $display("FAIL blink_first_toggle got=%0d exp=1..4", c);
            else n_pass++;
            if (c >= 1) begin
                for (int i = c; i < 16; i++) begin
                    logic [7:0] e;
                    e = ((((i - c) / 4) % 2) == 0) ? v[c] : (v[c] ^ 8'h03);
                    n_total++;
                    if (v[i] !== e || (v[i] !== 8'h01 && v[i] !== 8'h02))
                        $display("FAIL blink_pattern[%0d] got=%h exp=%h", i, v[i], e);
                    else n_pass++;
                end
            end
        end
`else
        n_total++;
        if (rd !== 32'h0) $display("FAIL blink_reads_zero got=%h exp=00000000", rd);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (v[i] !== 8'h01) $display("FAIL blink_disabled_out[%0d] got=%h exp=01", i, v[i]);
            else n_pass++;
        end
`endif
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset;
        test_outputs;
        test_bus_qualify;
        test_edge_irq;
        test_set_wins;
        test_any_edge;
        test_async_reset;
        test_blink;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
